bus_write_buffer: RTL and testbench



---
 rtl/bus_wb_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 97 +++++++++
 rtl/bus_write_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_bus_write_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_wb_pkg.sv
// bus_wb_pkg: shared types and widths for the posted-write buffer.
//   ADDR_W / DATA_W : CPU/MemoryUnit bus widths
//   wb_state_e      : drain FSM states
//   wb_entry_t      : one buffered write {address, data}
package bus_wb_pkg;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN_ISSUE,
    DRAIN_WAIT,
    READ_ISSUE,
    READ_WAIT
  } wb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order circular buffer of pending writes.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (drops all entries)
//   push, push_entry   : write an entry at the tail
//   pop                : retire the head entry
//   head               : current head entry
//   full, empty, count : occupancy, from registered state only
// Optional (macro WB_READ_FORWARD_EN):
//   lookup_addr        : address to search for
//   lookup_hit/data    : youngest valid entry matching lookup_addr
module wb_fifo
  import bus_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_READ_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));

`ifdef WB_READ_FORWARD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (mem_q[idx].address == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_q[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/bus_write_buffer.sv
// bus_write_buffer: posted-write buffer between CPU and MemoryUnit.
// Writes are acknowledged after one busy cycle and drained in order in the
// background; reads wait for the buffer to drain, then go to the MemoryUnit.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   cpu_address/data/we/start          : CPU request (start is a 1-cycle pulse)
//   cpu_busy, cpu_q                    : CPU handshake and registered read data
//   mu_address/data/we/start           : MemoryUnit request (registered)
//   mu_busy, mu_q                      : MemoryUnit response
//   wb_empty                           : nothing buffered, no access in flight
// Optional (macro WB_READ_FORWARD_EN): reads below IO_BASE that hit a buffered
// write return the youngest matching data without a MemoryUnit access.
module bus_write_buffer
  import bus_wb_pkg::*;
#(
  parameter int unsigned  DEPTH   = 4,
  parameter logic [26:0]  IO_BASE = 27'h7000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] cpu_address,
  input  logic [31:0] cpu_data,
  input  logic        cpu_we,
  input  logic        cpu_start,
  output logic        cpu_busy,
  output logic [31:0] cpu_q,
  output logic [26:0] mu_address,
  output logic [31:0] mu_data,
  output logic        mu_we,
  output logic        mu_start,
  input  logic        mu_busy,
  input  logic [31:0] mu_q,
  output logic        wb_empty
);

  wb_state_e   state_q, state_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic [31:0] cpu_q_q, cpu_q_d;
  logic        mu_start_q, mu_start_d;
  logic        mu_we_q, mu_we_d;
  logic [26:0] mu_address_q, mu_address_d;
  logic [31:0] mu_data_q, mu_data_d;
  logic        mu_busy_q;
  logic        wr_pend_q, wr_pend_d;
  wb_entry_t   wr_entry_q, wr_entry_d;
  logic        rd_pend_q, rd_pend_d;
  logic [26:0] rd_addr_q, rd_addr_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t              fifo_push_entry, fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   accept, mu_fall;

`ifdef WB_READ_FORWARD_EN
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (fifo_push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
`ifdef WB_READ_FORWARD_EN
    ,
    .lookup_addr(cpu_address),
    .lookup_hit (fwd_hit),
    .lookup_data(fwd_data)
`endif
  );

  assign accept  = cpu_start && !cpu_busy_q;
  assign mu_fall = mu_busy_q && !mu_busy;

  always_comb begin
    state_d         = state_q;
    cpu_q_d         = cpu_q_q;
    mu_start_d      = 1'b0;
    mu_we_d         = mu_we_q;
    mu_address_d    = mu_address_q;
    mu_data_d       = mu_data_q;
    wr_pend_d       = wr_pend_q;
    wr_entry_d      = wr_entry_q;
    rd_pend_d       = rd_pend_q;
    rd_addr_d       = rd_addr_q;
    fifo_push       = 1'b0;
    fifo_push_entry = wr_entry_q;
    fifo_pop        = 1'b0;

    // A stalled write retries against the registered count only.
    if (wr_pend_q && !fifo_full) begin
      fifo_push = 1'b1;
      wr_pend_d = 1'b0;
    end

    if (accept) begin
      if (cpu_we) begin
        if (!fifo_full) begin
          fifo_push       = 1'b1;
          fifo_push_entry = '{address: cpu_address, data: cpu_data};
        end else begin
          wr_pend_d  = 1'b1;
          wr_entry_d = '{address: cpu_address, data: cpu_data};
        end
      end else begin
`ifdef WB_READ_FORWARD_EN
        if ((cpu_address < IO_BASE) && fwd_hit) begin
          cpu_q_d = fwd_data;
        end else begin
          rd_pend_d = 1'b1;
          rd_addr_d = cpu_address;
        end
`else
        rd_pend_d = 1'b1;
        rd_addr_d = cpu_address;
`endif
      end
    end

    // Drain takes priority: a pending read only issues once the FIFO is empty.
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d      = DRAIN_ISSUE;
          mu_start_d   = 1'b1;
          mu_we_d      = 1'b1;
          mu_address_d = fifo_head.address;
          mu_data_d    = fifo_head.data;
        end else if (rd_pend_q) begin
          state_d      = READ_ISSUE;
          mu_start_d   = 1'b1;
          mu_we_d      = 1'b0;
          mu_address_d = rd_addr_q;
        end
      end
      DRAIN_ISSUE: state_d = DRAIN_WAIT;
      DRAIN_WAIT: begin
        if (mu_fall) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end
      end
      READ_ISSUE: state_d = READ_WAIT;
      READ_WAIT: begin
        if (mu_fall) begin
          cpu_q_d   = mu_q;
          rd_pend_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy covers the accept cycle plus any request still waiting.
    cpu_busy_d = accept || wr_pend_d || rd_pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cpu_busy_q   <= 1'b0;
      cpu_q_q      <= '0;
      mu_start_q   <= 1'b0;
      mu_we_q      <= 1'b0;
      mu_address_q <= '0;
      mu_data_q    <= '0;
      mu_busy_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_entry_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      cpu_busy_q   <= cpu_busy_d;
      cpu_q_q      <= cpu_q_d;
      mu_start_q   <= mu_start_d;
      mu_we_q      <= mu_we_d;
      mu_address_q <= mu_address_d;
      mu_data_q    <= mu_data_d;
      mu_busy_q    <= mu_busy;
      wr_pend_q    <= wr_pend_d;
      wr_entry_q   <= wr_entry_d;
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign cpu_busy   = cpu_busy_q;
  assign cpu_q      = cpu_q_q;
  assign mu_start   = mu_start_q;
  assign mu_we      = mu_we_q;
  assign mu_address = mu_address_q;
  assign mu_data    = mu_data_q;
  assign wb_empty   = (fifo_count == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_bus_write_buffer.sv
// Directed bench for bus_write_buffer with a variable-latency MemoryUnit model.
module tb_bus_write_buffer;

  localparam logic [26:0] IO_BASE = 27'h7000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] cpu_address;
  logic [31:0] cpu_data;
  logic        cpu_we;
  logic        cpu_start;
  logic        cpu_busy;
  logic [31:0] cpu_q;
  logic [26:0] mu_address;
  logic [31:0] mu_data;
  logic        mu_we;
  logic        mu_start;
  logic        mu_busy;
  logic [31:0] mu_q;
  logic        wb_empty;

  int checks   = 0;
  int failures = 0;

  bus_write_buffer #(.DEPTH(4), .IO_BASE(IO_BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_address(cpu_address),
    .cpu_data   (cpu_data),
    .cpu_we     (cpu_we),
    .cpu_start  (cpu_start),
    .cpu_busy   (cpu_busy),
    .cpu_q      (cpu_q),
    .mu_address (mu_address),
    .mu_data    (mu_data),
    .mu_we      (mu_we),
    .mu_start   (mu_start),
    .mu_busy    (mu_busy),
    .mu_q       (mu_q),
    .wb_empty   (wb_empty)
  );

  always #5 clk = ~clk;

  // MemoryUnit model: busy for mu_lat cycles after start, logs every access.
  int unsigned  mu_lat = 3;
  int unsigned  mu_cnt;
  logic [31:0]  mem [logic [26:0]];
  logic [26:0]  log_addr [$];
  logic         log_we [$];

  always @(posedge clk) begin
    if (reset) begin
      mu_busy <= 1'b0;
      mu_cnt  <= 0;
      mu_q    <= '0;
    end else if (mu_start) begin
      mu_busy <= 1'b1;
      mu_cnt  <= mu_lat - 1;
      log_addr.push_back(mu_address);
      log_we.push_back(mu_we);
      if (mu_we) mem[mu_address] = mu_data;
      else       mu_q <= mem.exists(mu_address) ? mem[mu_address] : 32'h0;
    end else if (mu_busy) begin
      if (mu_cnt == 0) mu_busy <= 1'b0;
      else             mu_cnt  <= mu_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
  endtask

  // One CPU request; returns how many sampled cycles cpu_busy stayed high.
  task automatic cpu_op(input logic we, input logic [26:0] a, input logic [31:0] d,
                        output int busy_cycles);
    cpu_we      = we;
    cpu_address = a;
    cpu_data    = d;
    cpu_start   = 1'b1;
    tick();
    cpu_start   = 1'b0;
    busy_cycles = 0;
    while (cpu_busy === 1'b1 && busy_cycles < 300) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic wait_empty(output bit ok);
    int n = 0;
    while (wb_empty !== 1'b1 && n < 300) begin
      n++;
      tick();
    end
    ok = (wb_empty === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({cpu_busy, cpu_q} !== 33'h0) begin
      failures++;
      $display("FAIL reset_cpu: busy=%b q=%h required busy=0 q=0", cpu_busy, cpu_q);
    end
    checks++;
    if ({mu_start, mu_we, mu_address, mu_data} !== 61'h0) begin
      failures++;
      $display("FAIL reset_mu: start=%b we=%b addr=%h data=%h required all 0",
               mu_start, mu_we, mu_address, mu_data);
    end
    checks++;
    if (wb_empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_empty: wb_empty=%b required 1", wb_empty);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    bit ok;
    mu_lat = 3;
    clear_log();
    cpu_we = 1'b1; cpu_address = 27'h100; cpu_data = 32'hDEADBEEF; cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    checks++;
    if (cpu_busy !== 1'b1 || wb_empty !== 1'b0) begin
      failures++;
      $display("FAIL sw_cycle1: busy=%b empty=%b required busy=1 empty=0", cpu_busy, wb_empty);
    end
    tick();
    checks++;
    if (cpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL sw_busy_drop: busy=%b required 0", cpu_busy);
    end
    checks++;
    if ({mu_start, mu_we, mu_address, mu_data} !== {1'b1, 1'b1, 27'h100, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL sw_issue: start=%b we=%b addr=%h data=%h required 1 1 100 deadbeef",
               mu_start, mu_we, mu_address, mu_data);
    end
    wait_empty(ok);
    checks++;
    if (!ok || log_addr.size() != 1) begin
      failures++;
      $display("FAIL sw_drain: empty=%0d accesses=%0d required empty=1 accesses=1", ok, log_addr.size());
    end
  endtask

  task automatic test_full_stall();
    int bc [5];
    int exp_bc [5] = '{1, 1, 1, 1, 4};
    bit ok;
    mu_lat = 8;
    clear_log();
    for (int i = 0; i < 5; i++) cpu_op(1'b1, 27'(i), 32'(32'hA0 + i), bc[i]);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bc[i] !== exp_bc[i]) begin
        failures++;
        $display("FAIL stall_busy[%0d]: busy_cycles=%0d required %0d", i, bc[i], exp_bc[i]);
      end
    end
    wait_empty(ok);
    checks++;
    if (!ok || log_addr.size() != 5) begin
      failures++;
      $display("FAIL stall_count: empty=%0d accesses=%0d required empty=1 accesses=5", ok, log_addr.size());
    end
    for (int i = 0; i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 27'(i) || log_we[i] !== 1'b1) begin
        failures++;
        $display("FAIL stall_order[%0d]: addr=%h we=%b required addr=%h we=1", i, log_addr[i], log_we[i], i);
      end
    end
  endtask

  task automatic test_read_after_write();
    int bc;
    bit ok;
    mu_lat = 3;
    clear_log();
    cpu_op(1'b1, 27'h200, 32'h12345678, bc);
    checks++;
    if (bc !== 1) begin
      failures++;
      $display("FAIL raw_write_busy: busy_cycles=%0d required 1", bc);
    end
    cpu_op(1'b0, 27'h200, 32'h0, bc);
    checks++;
    if (cpu_q !== 32'h12345678) begin
      failures++;
      $display("FAIL raw_data: q=%h required 12345678", cpu_q);
    end
    wait_empty(ok);
`ifdef WB_READ_FORWARD_EN
    checks++;
    if (bc !== 1 || log_addr.size() != 1) begin
      failures++;
      $display("FAIL raw_fwd: busy_cycles=%0d accesses=%0d required 1 and 1", bc, log_addr.size());
    end
`else
    checks++;
    if (bc !== 10) begin
      failures++;
      $display("FAIL raw_latency: busy_cycles=%0d required 10", bc);
    end
    checks++;
    if (log_addr.size() != 2 || log_we[0] !== 1'b1 || log_we[1] !== 1'b0 || log_addr[1] !== 27'h200) begin
      failures++;
      $display("FAIL raw_order: accesses=%0d required write then read of 200", log_addr.size());
    end
`endif
  endtask

  task automatic test_forward();
    int bc;
    bit ok;
    mu_lat = 3;
    clear_log();
    cpu_op(1'b1, 27'h300, 32'd1, bc);
    cpu_op(1'b1, 27'h300, 32'd2, bc);
    cpu_op(1'b0, 27'h300, 32'h0, bc);
    checks++;
    if (cpu_q !== 32'd2) begin
      failures++;
      $display("FAIL fwd_data: q=%h required 2", cpu_q);
    end
    wait_empty(ok);
`ifdef WB_READ_FORWARD_EN
    checks++;
    if (bc !== 1 || log_addr.size() != 2 || log_we[0] !== 1'b1 || log_we[1] !== 1'b1) begin
      failures++;
      $display("FAIL fwd_hit: busy_cycles=%0d accesses=%0d required 1 and 2 writes", bc, log_addr.size());
    end
`else
    checks++;
    if (bc !== 14 || log_addr.size() != 3 || log_we[2] !== 1'b0) begin
      failures++;
      $display("FAIL fwd_nohit: busy_cycles=%0d accesses=%0d required 14 and 3", bc, log_addr.size());
    end
`endif
    // I/O space is never served from the buffer.
    clear_log();
    cpu_op(1'b1, IO_BASE, 32'd5, bc);
    cpu_op(1'b1, IO_BASE, 32'd6, bc);
    cpu_op(1'b0, IO_BASE, 32'h0, bc);
    wait_empty(ok);
    checks++;
    if (cpu_q !== 32'd6 || bc !== 14) begin
      failures++;
      $display("FAIL io_read: q=%h busy_cycles=%0d required 6 and 14", cpu_q, bc);
    end
    checks++;
    if (log_addr.size() != 3 || log_we[2] !== 1'b0 || log_addr[2] !== IO_BASE) begin
      failures++;
      $display("FAIL io_access: accesses=%0d required 3 ending in read", log_addr.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    int bc;
    mu_lat = 8;
    cpu_op(1'b1, 27'h400, 32'h11, bc);
    cpu_op(1'b1, 27'h401, 32'h22, bc);
    cpu_op(1'b1, 27'h402, 32'h33, bc);
    checks++;
    if (mu_busy !== 1'b1 || wb_empty !== 1'b0) begin
      failures++;
      $display("FAIL rmd_inflight: mu_busy=%b empty=%b required 1 0", mu_busy, wb_empty);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({cpu_busy, cpu_q, mu_start, mu_we, mu_address, mu_data} !== 94'h0 || wb_empty !== 1'b1) begin
      failures++;
      $display("FAIL rmd_reset: busy=%b q=%h start=%b we=%b addr=%h data=%h empty=%b required zeros, empty=1",
               cpu_busy, cpu_q, mu_start, mu_we, mu_address, mu_data, wb_empty);
    end
    reset = 1'b0;
    clear_log();
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (log_addr.size() != 0 || wb_empty !== 1'b1) begin
      failures++;
      $display("FAIL rmd_quiet: accesses=%0d empty=%b required 0 and 1", log_addr.size(), wb_empty);
    end
  endtask

  initial begin
    reset       = 1'b1;
    cpu_start   = 1'b0;
    cpu_we      = 1'b0;
    cpu_address = '0;
    cpu_data    = '0;
    test_reset();
    test_single_write();
    test_full_stall();
    test_read_after_write();
    test_forward();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
